// File: rtl/slot_pkg.sv
// Shared slot-machine types and default widths.
// Reel FSM state enum plus symbol/reel-count defaults.
package slot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } reel_state_t;

  localparam int SLOT_SYM_W     = 3;
  localparam int SLOT_NUM_REELS = 3;

  // Counter width that stays legal when the range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// TICK_DIV modulo counter; tick is high for the cycle in which it wraps.
// Ports: clk, reset (async low), clear (sync), en, tick.
module tick_divider
  import slot_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_w(TICK_DIV);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(TICK_DIV - 1));
  assign tick = en && wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/reel_spin_ctrl.sv
// Reel sequencing FSM: spin/animate reels, stop them in order from LFSR.
// Ports: clk, reset (async low), start, stop, lfsr_in -> reel_sym, busy,
// done, win. Optional macro AUTO_STOP_EN adds an idle-stop timeout.
module reel_spin_ctrl
  import slot_pkg::*;
#(
  parameter int NUM_REELS   = SLOT_NUM_REELS,
  parameter int SYM_W       = SLOT_SYM_W,
  parameter int LFSR_W      = 15,
  parameter int TICK_DIV    = 4,
  parameter int AUTO_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [LFSR_W-1:0]          lfsr_in,
  output logic [NUM_REELS*SYM_W-1:0] reel_sym,
  output logic                       busy,
  output logic                       done,
  output logic                       win
);

  localparam int KW = cnt_w(NUM_REELS);

  reel_state_t                       state;
  logic [KW-1:0]                     k;
  logic [NUM_REELS-1:0][SYM_W-1:0]   reel_q;
  logic [NUM_REELS-1:0][SYM_W-1:0]   reel_nxt;
  logic                              spin;
  logic                              tick;
  logic                              stop_any;
  logic                              last;
  logic                              all_eq;

  assign spin     = (state == SPIN);
  assign last     = (k == KW'(NUM_REELS - 1));
  assign reel_sym = reel_q;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(!spin),
    .en   (spin),
    .tick (tick)
  );

`ifdef AUTO_STOP_EN
  localparam int AW = cnt_w(AUTO_CYCLES);

  logic [AW-1:0] idle_cnt;
  logic          auto_stop;

  assign auto_stop = spin && (idle_cnt == AW'(AUTO_CYCLES - 1));
  // External and internal stop in the same cycle merge into one stop.
  assign stop_any  = spin && (stop || auto_stop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!spin || stop || auto_stop) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + AW'(1);
    end
  end
`else
  localparam int unused_auto = AUTO_CYCLES;

  assign stop_any = spin && stop;
`endif

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_in[LFSR_W-1:SYM_W];

  // Load beats increment when a stop lands on a tick wrap.
  always_comb begin
    reel_nxt = reel_q;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (tick && (KW'(i) >= k)) begin
        reel_nxt[i] = reel_q[i] + SYM_W'(1);
      end
      if (stop_any && (KW'(i) == k)) begin
        reel_nxt[i] = lfsr_in[SYM_W-1:0];
      end
    end
  end

  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (reel_nxt[i] != reel_nxt[0]) begin
        all_eq = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      k      <= '0;
      reel_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      win    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SPIN;
            busy  <= 1'b1;
            win   <= 1'b0;
            k     <= '0;
          end
        end
        SPIN: begin
          reel_q <= reel_nxt;
          if (stop_any) begin
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
              win   <= all_eq;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reel_spin_ctrl.sv
// Self-checking bench for reel_spin_ctrl (default build, TICK_DIV=4).
// Table vectors plus hand sequences, checked through a scoreboard queue.
module tb_reel_spin_ctrl;

  localparam int NR = 3;
  localparam int SW = 3;
  localparam int LW = 15;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [LW-1:0]   lfsr_in = '0;
  logic [NR*SW-1:0] reel_sym;
  logic            busy;
  logic            done;
  logic            win;

  reel_spin_ctrl #(
    .NUM_REELS  (NR),
    .SYM_W      (SW),
    .LFSR_W     (LW),
    .TICK_DIV   (TD),
    .AUTO_CYCLES(20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .lfsr_in (lfsr_in),
    .reel_sym(reel_sym),
    .busy    (busy),
    .done    (done),
    .win     (win)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic          sp;
    logic [LW-1:0] lf;
    logic [8:0]    sym;
    logic          bz;
    logic          dn;
    logic          wn;
    string         tag;
  } vec_t;

  typedef struct {
    logic [8:0] sym;
    logic       bz;
    logic       dn;
    logic       wn;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pack(input int a0, input int a1,
                                      input int a2);
    logic [2:0] b0, b1, b2;
    b0 = 3'(a0);
    b1 = 3'(a1);
    b2 = 3'(a2);
    return {b2, b1, b0};
  endfunction

  // Drive one cycle of stimulus and queue what must appear after the edge.
  task automatic drive(input logic st, input logic sp,
                       input logic [LW-1:0] lf, input logic [8:0] sym,
                       input logic bz, input logic dn, input logic wn,
                       input string tag);
    exp_t e;
    @(negedge clk);
    start   = st;
    stop    = sp;
    lfsr_in = lf;
    e.sym = sym;
    e.bz  = bz;
    e.dn  = dn;
    e.wn  = wn;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      #1;
      e = sbq.pop_front();
      chk({e.tag, ".sym"},  32'(reel_sym), 32'(e.sym));
      chk({e.tag, ".busy"}, 32'(busy),     32'(e.bz));
      chk({e.tag, ".done"}, 32'(done),     32'(e.dn));
      chk({e.tag, ".win"},  32'(win),      32'(e.wn));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[14];
  int   base[3];
  int   val[3];
  int   nstop;
  logic sp;
  logic [LW-1:0] lf;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 15'h0005, 9'h000, 1'b0, 1'b0, 1'b0, "stop_idle"};
    tbl[1]  = '{1'b1, 1'b1, 15'h0007, 9'h000, 1'b1, 1'b0, 1'b0, "start_stop"};
    tbl[2]  = '{1'b0, 1'b0, 15'h0000, 9'h000, 1'b1, 1'b0, 1'b0, "spin_t1"};
    tbl[3]  = '{1'b1, 1'b0, 15'h0000, 9'h000, 1'b1, 1'b0, 1'b0, "start_in_spin"};
    tbl[4]  = '{1'b0, 1'b0, 15'h0000, 9'h000, 1'b1, 1'b0, 1'b0, "spin_t3"};
    tbl[5]  = '{1'b0, 1'b0, 15'h0000, 9'h049, 1'b1, 1'b0, 1'b0, "first_tick"};
    tbl[6]  = '{1'b0, 1'b0, 15'h0000, 9'h049, 1'b1, 1'b0, 1'b0, "spin_t5"};
    tbl[7]  = '{1'b0, 1'b0, 15'h0000, 9'h049, 1'b1, 1'b0, 1'b0, "spin_t6"};
    tbl[8]  = '{1'b0, 1'b0, 15'h0000, 9'h049, 1'b1, 1'b0, 1'b0, "spin_t7"};
    tbl[9]  = '{1'b0, 1'b1, 15'h7FF9, 9'h091, 1'b1, 1'b0, 1'b0, "stop_on_wrap"};
    tbl[10] = '{1'b0, 1'b1, 15'h0002, 9'h091, 1'b1, 1'b0, 1'b0, "stop_r1"};
    tbl[11] = '{1'b0, 1'b1, 15'h0003, 9'h0D1, 1'b1, 1'b1, 1'b0, "last_nowin"};
    tbl[12] = '{1'b0, 1'b0, 15'h0000, 9'h0D1, 1'b0, 1'b0, 1'b0, "done_idle"};
    tbl[13] = '{1'b0, 1'b1, 15'h0007, 9'h0D1, 1'b0, 1'b0, 1'b0, "stop_idle2"};

    // Reset state.
    #2;
    chk("rst.sym",  32'(reel_sym), 32'h0);
    chk("rst.busy", 32'(busy),     32'h0);
    chk("rst.done", 32'(done),     32'h0);
    chk("rst.win",  32'(win),      32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Animation: every reel steps once per TD clocks, in lockstep.
    for (int j = 0; j < 40; j++) begin
      drive(j == 0, 1'b0, 15'h0,
            pack((j / TD) % 8, (j / TD) % 8, (j / TD) % 8),
            1'b1, 1'b0, 1'b0, $sformatf("spin%0d", j));
    end
    @(negedge clk);
    start = 1'b0;

    // Asynchronous reset mid-spin, away from any edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst.sym",  32'(reel_sym), 32'h0);
    chk("arst.busy", 32'(busy),     32'h0);
    chk("arst.done", 32'(done),     32'h0);
    chk("arst.win",  32'(win),      32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b1, 15'h0006, 9'h000, 1'b0, 1'b0, 1'b0,
            $sformatf("post_rst_stop%0d", j));
    end

    // Table: edge cases and the no-win stop sequence.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].lf, tbl[i].sym,
            tbl[i].bz, tbl[i].dn, tbl[i].wn, tbl[i].tag);
    end

    // Winning sequence from reels {3,2,1}; stops 10 cycles apart.
    base[0] = 1;
    base[1] = 2;
    base[2] = 3;
    nstop = 0;
    for (int j = 0; j < 36; j++) begin
      sp = (j == 10) || (j == 20) || (j == 30);
      lf = sp ? 15'h0005 : 15'($urandom_range(0, 32767));
      if (sp) nstop++;
      for (int i = 0; i < 3; i++) begin
        if (i < nstop) val[i] = 5;
        else val[i] = (base[i] + j / TD) % 8;
      end
      drive(j == 0, sp, lf, pack(val[0], val[1], val[2]),
            j <= 30, j == 30, j >= 30, $sformatf("win%0d", j));
    end
    drive(1'b1, 1'b0, 15'h0, 9'h16D, 1'b1, 1'b0, 1'b0, "restart_clr_win");
    drive(1'b0, 1'b0, 15'h0, 9'h16D, 1'b1, 1'b0, 1'b0, "restart_t1");
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
